stack_program_sequencer: RTL and testbench

Upstream instruction feeder for `stack_cpu`. Holds a small nibble program, then replays it onto the CPU's 4-bit `inbits` input with per-opcode cycle timing, so a program runs without hand-clocking nibbles. It also owns the CPU's reset line. Outputs wire directly to `io_in[1]` (reset) and `io_in[5:2]` (inbits) of `stack_cpu`, both driven from the same `clk`.

---
 rtl/stack_program_sequencer_if.sv | 28 ++
 rtl/stack_program_sequencer.sv | 190 +++++++++++++++++++
 tb/tb_stack_program_sequencer.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/stack_program_sequencer_if.sv
// Load handshake, run control and CPU-facing outputs of stack_program_sequencer.
// Signal names are prefixed from the sequencer's point of view (i_ = into it, o_ = out of it).
interface stack_program_sequencer_if #(
    parameter int ADDR_BITS = 4
);
    logic                 i_load_valid;
    logic [3:0]           i_load_nibble;
    logic                 o_load_ready;
    logic                 i_clear;
    logic                 i_run;
    logic                 o_cpu_rst;
    logic [3:0]           o_cpu_inbits;
    logic                 o_busy;
    logic                 o_done;
    logic [ADDR_BITS:0]   o_prog_len;

    // Program source / controller side.
    modport master (
        output i_load_valid, i_load_nibble, i_clear, i_run,
        input  o_load_ready, o_cpu_rst, o_cpu_inbits, o_busy, o_done, o_prog_len
    );

    // Sequencer side.
    modport slave (
        input  i_load_valid, i_load_nibble, i_clear, i_run,
        output o_load_ready, o_cpu_rst, o_cpu_inbits, o_busy, o_done, o_prog_len
    );
endinterface

// File: rtl/stack_program_sequencer.sv
// stack_program_sequencer: stores a nibble program and replays it onto the
// stack_cpu inbits input with per-opcode timing, owning the CPU reset line.
// Optional build macro SEQUENCER_LOOP_EN: at program end, wrap to the first
// instruction (no CPU reset) while run stays high.
//
// state | meaning
// IDLE  | after rst; CPU held in reset, inbits 0, loads accepted
// CRST  | 2-cycle CPU reset pulse before the first fetch
// FETCH | opcode on inbits for exactly one cycle
// EXEC  | L-1 cycles of operand (or 0) on inbits
// DONE  | program finished; CPU out of reset running NOOPs, loads accepted
module stack_program_sequencer #(
    parameter int PROG_DEPTH = 16,
    parameter int ADDR_BITS  = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    stack_program_sequencer_if.slave bus
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CRST  = 3'd1;
    localparam logic [2:0] S_FETCH = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam logic [ADDR_BITS:0] DEPTH_C = PROG_DEPTH[ADDR_BITS:0];
    localparam logic [ADDR_BITS:0] ONE_C   = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0] TWO_C   = {{(ADDR_BITS-1){1'b0}}, 2'b10};

    logic [3:0]         r_mem [0:PROG_DEPTH-1];
    logic [2:0]         r_state;
    logic [ADDR_BITS:0] r_ptr;
    logic [ADDR_BITS:0] r_prog_len;
    logic [1:0]         r_cnt;
    logic [3:0]         r_inbits;
    logic               r_cpu_rst;

    logic [2:0]         w_state_nx;
    logic [ADDR_BITS:0] w_ptr_nx;
    logic [1:0]         w_cnt_nx;
    logic [3:0]         w_inbits_nx;
    logic               w_cpu_rst_nx;

    logic               w_idle_like;
    logic               w_load_fire;
    logic [ADDR_BITS:0] w_ptr_p1;
    logic [ADDR_BITS:0] w_ptr_p2;
    logic               w_has_opnd;
    logic [3:0]         w_rd_next;
    logic [3:0]         w_rd_opnd;
    logic               w_op_takes_opnd;
    logic [1:0]         w_exec_cnt;

    assign w_idle_like = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_load_fire = w_idle_like && bus.i_load_valid && !bus.i_clear &&
                         (r_prog_len < DEPTH_C);
    assign w_ptr_p1    = r_ptr + ONE_C;
    assign w_ptr_p2    = r_ptr + TWO_C;
    assign w_has_opnd  = (w_ptr_p1 < r_prog_len);
    // Combinational reads: next opcode is prefetched while EXEC is still running.
    assign w_rd_next   = (r_ptr < r_prog_len) ? r_mem[r_ptr[ADDR_BITS-1:0]] : 4'h0;
    assign w_rd_opnd   = w_has_opnd ? r_mem[w_ptr_p1[ADDR_BITS-1:0]] : 4'h0;

    assign bus.o_load_ready = w_idle_like && (r_prog_len < DEPTH_C);
    assign bus.o_cpu_rst    = r_cpu_rst;
    assign bus.o_cpu_inbits = r_inbits;
    assign bus.o_busy       = (r_state == S_CRST) || (r_state == S_FETCH) || (r_state == S_EXEC);
    assign bus.o_done       = (r_state == S_DONE);
    assign bus.o_prog_len   = r_prog_len;

    // Decode the opcode held on inbits during FETCH: operand use and EXEC length.
    always_comb begin
        w_op_takes_opnd = 1'b0;
        w_exec_cnt      = 2'd0;
        case (r_inbits)
            4'h1, 4'h6, 4'h7, 4'h8: begin
                w_op_takes_opnd = 1'b1;
                w_exec_cnt      = 2'd1;
            end
            4'h2, 4'h5:                w_exec_cnt = 2'd1;
            4'h9, 4'hA, 4'hC, 4'hD:    w_exec_cnt = 2'd2;
            default:                   w_exec_cnt = 2'd0;
        endcase
    end

    // Next-state and next-output logic; outputs are registered alongside the state.
    always_comb begin
        w_state_nx   = r_state;
        w_ptr_nx     = r_ptr;
        w_cnt_nx     = r_cnt;
        w_inbits_nx  = r_inbits;
        w_cpu_rst_nx = r_cpu_rst;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (bus.i_run) begin
                    w_ptr_nx    = '0;
                    w_inbits_nx = 4'h0;
                    if (r_prog_len != '0) begin
                        w_state_nx   = S_CRST;
                        w_cpu_rst_nx = 1'b1;
                        w_cnt_nx     = 2'd1;
                    end else begin
                        w_state_nx   = S_DONE;
                        w_cpu_rst_nx = 1'b0;
                    end
                end
            end
            S_CRST: begin
                if (r_cnt != 2'd0) begin
                    w_cnt_nx = r_cnt - 2'd1;
                end else begin
                    w_state_nx   = S_FETCH;
                    w_cpu_rst_nx = 1'b0;
                    w_inbits_nx  = w_rd_next;
                end
            end
            S_FETCH: begin
                w_state_nx  = S_EXEC;
                w_cnt_nx    = w_exec_cnt;
                w_inbits_nx = w_op_takes_opnd ? w_rd_opnd : 4'h0;
                // A truncated operand leaves the pointer exactly at prog_len.
                w_ptr_nx    = (w_op_takes_opnd && w_has_opnd) ? w_ptr_p2 : w_ptr_p1;
            end
            S_EXEC: begin
                if (r_cnt != 2'd0) begin
                    w_cnt_nx = r_cnt - 2'd1;
                end else if (r_ptr < r_prog_len) begin
                    w_state_nx  = S_FETCH;
                    w_inbits_nx = w_rd_next;
                end else begin
`ifdef SEQUENCER_LOOP_EN
                    if (bus.i_run) begin
                        w_state_nx  = S_FETCH;
                        w_ptr_nx    = '0;
                        w_inbits_nx = r_mem[0];
                    end else begin
                        w_state_nx  = S_DONE;
                        w_inbits_nx = 4'h0;
                    end
`else
                    w_state_nx  = S_DONE;
                    w_inbits_nx = 4'h0;
`endif
                end
            end
            default: begin
                w_state_nx   = S_IDLE;
                w_cpu_rst_nx = 1'b1;
                w_inbits_nx  = 4'h0;
            end
        endcase
    end

    // State, pointer, timer and registered CPU outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cnt     <= 2'd0;
            r_inbits  <= 4'h0;
            r_cpu_rst <= 1'b1;
        end else begin
            r_state   <= w_state_nx;
            r_ptr     <= w_ptr_nx;
            r_cnt     <= w_cnt_nx;
            r_inbits  <= w_inbits_nx;
            r_cpu_rst <= w_cpu_rst_nx;
        end
    end

    // Program length: clear wins over a load in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prog_len <= '0;
        end else if (w_idle_like && bus.i_clear) begin
            r_prog_len <= '0;
        end else if (w_load_fire) begin
            r_prog_len <= r_prog_len + ONE_C;
        end
    end

    // Program memory write; contents survive rst and clear.
    always_ff @(posedge clk) begin
        if (w_load_fire) begin
            r_mem[r_prog_len[ADDR_BITS-1:0]] <= bus.i_load_nibble;
        end
    end

endmodule

// File: tb/tb_stack_program_sequencer.sv
// Scoreboard bench for stack_program_sequencer: stimulus pushes the expected
// per-cycle {busy, done, cpu_rst, inbits} stream, a monitor pops and compares.
module tb_stack_program_sequencer;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;
    logic mon_en;
    logic done_prev;
    logic [6:0] exp_q [$];
    logic [3:0] prog_q [$];

    stack_program_sequencer_if #(.ADDR_BITS(4)) bus ();

    stack_program_sequencer #(.PROG_DEPTH(16), .ADDR_BITS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Monitor: every cycle the DUT is busy, plus the cycle done rises, is one output.
    always @(negedge clk) begin
        logic [6:0] got;
        logic [6:0] e;
        if (mon_en) begin
            if (bus.o_busy || (bus.o_done && !done_prev)) begin
                got = {bus.o_busy, bus.o_done, bus.o_cpu_rst, bus.o_cpu_inbits};
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_output got=%b required=none", got);
                end else begin
                    e = exp_q.pop_front();
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL stream got={busy,done,rst,bits}=%b required=%b", got, e);
                    end
                end
            end
        end
        done_prev = bus.o_done;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic push_bits(input logic [3:0] b);
        exp_q.push_back({3'b100, b});
    endtask

    task automatic push_crst();
        exp_q.push_back(7'b1010000);
        exp_q.push_back(7'b1010000);
    endtask

    task automatic push_done();
        exp_q.push_back(7'b0100000);
    endtask

    // Reference model: walk the program as a list of instructions.
    function automatic int op_len(input logic [3:0] op);
        case (op)
            4'h0, 4'h3, 4'h4, 4'hB, 4'hE, 4'hF: return 2;
            4'h9, 4'hA, 4'hC, 4'hD:             return 4;
            default:                            return 3;
        endcase
    endfunction

    function automatic bit has_opnd(input logic [3:0] op);
        return (op == 4'h1) || (op == 4'h6) || (op == 4'h7) || (op == 4'h8);
    endfunction

    task automatic push_model_pass();
        int i;
        logic [3:0] op;
        logic [3:0] val;
        i = 0;
        while (i < prog_q.size()) begin
            op  = prog_q[i];
            val = 4'h0;
            if (has_opnd(op) && (i + 1 < prog_q.size())) val = prog_q[i+1];
            push_bits(op);
            for (int k = 1; k < op_len(op); k++) push_bits(val);
            i += has_opnd(op) ? 2 : 1;
        end
    endtask

    task automatic do_clear();
        bus.i_clear = 1'b1;
        @(negedge clk);
        bus.i_clear = 1'b0;
    endtask

    task automatic load(input logic [3:0] v);
        bus.i_load_valid  = 1'b1;
        bus.i_load_nibble = v;
        @(negedge clk);
        bus.i_load_valid  = 1'b0;
    endtask

    task automatic load_prog();
        do_clear();
        for (int i = 0; i < prog_q.size(); i++) load(prog_q[i]);
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (!bus.o_done && k < budget) begin
            @(negedge clk);
            k++;
        end
        n_tests++;
        if (!bus.o_done) begin
            n_fail++;
            $display("FAIL done_timeout got=done0 required=done1 after %0d cycles", budget);
        end
        @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic run_and_wait(input int budget);
        bus.i_run = 1'b1;
        @(negedge clk);
        bus.i_run = 1'b0;
        wait_done(budget);
    endtask

    initial begin
        logic [3:0] seq [$];
        int len;
        n_tests = 0;
        n_fail  = 0;
        mon_en  = 1'b0;
        done_prev = 1'b0;
        rst = 1'b1;
        bus.i_load_valid  = 1'b0;
        bus.i_load_nibble = 4'h0;
        bus.i_clear = 1'b0;
        bus.i_run   = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        check("reset_cpu_rst", bus.o_cpu_rst, 1);
        check("reset_inbits", bus.o_cpu_inbits, 0);
        check("reset_busy", bus.o_busy, 0);
        check("reset_done", bus.o_done, 0);
        check("reset_prog_len", bus.o_prog_len, 0);
        check("reset_load_ready", bus.o_load_ready, 1);
        mon_en = 1'b1;

        // Empty program: straight to DONE, no CPU reset.
        push_done();
        run_and_wait(10);
        check("empty_cpu_rst", bus.o_cpu_rst, 0);

        // PUSH 5, PUSH 3, ADD, OUTL with the literal expected stream.
        prog_q = '{4'h1, 4'h5, 4'h1, 4'h3, 4'h8, 4'h0, 4'h3};
        load_prog();
        check("prog7_len", bus.o_prog_len, 7);
        seq = '{4'h1, 4'h5, 4'h5, 4'h1, 4'h3, 4'h3, 4'h8, 4'h0, 4'h0, 4'h3, 4'h0};
        push_crst();
        foreach (seq[i]) push_bits(seq[i]);
        push_done();
        run_and_wait(40);

        // MULT alone: 9,0,0,0.
        prog_q = '{4'h9};
        load_prog();
        push_crst();
        seq = '{4'h9, 4'h0, 4'h0, 4'h0};
        foreach (seq[i]) push_bits(seq[i]);
        push_done();
        run_and_wait(20);

        // Truncated PUSH: 1,0,0.
        prog_q = '{4'h1};
        load_prog();
        push_crst();
        seq = '{4'h1, 4'h0, 4'h0};
        foreach (seq[i]) push_bits(seq[i]);
        push_done();
        run_and_wait(20);

        // Fill to depth; the 17th write must be dropped.
        prog_q = {};
        for (int i = 0; i < 16; i++) prog_q.push_back(4'h0);
        load_prog();
        check("full_load_ready", bus.o_load_ready, 0);
        check("full_prog_len", bus.o_prog_len, 16);
        load(4'hF);
        check("full_17th_dropped", bus.o_prog_len, 16);
        push_crst();
        push_model_pass();
        push_done();
        run_and_wait(60);

        // Clear wins over a simultaneous load.
        bus.i_clear = 1'b1;
        bus.i_load_valid = 1'b1;
        bus.i_load_nibble = 4'h7;
        @(negedge clk);
        bus.i_clear = 1'b0;
        bus.i_load_valid = 1'b0;
        check("clear_wins", bus.o_prog_len, 0);

        // rst during the second EXEC cycle of MULT.
        prog_q = '{4'h9};
        load_prog();
        push_crst();
        push_bits(4'h9);
        push_bits(4'h0);
        push_bits(4'h0);
        bus.i_run = 1'b1;
        @(negedge clk);
        bus.i_run = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_cpu_rst", bus.o_cpu_rst, 1);
        check("midrst_inbits", bus.o_cpu_inbits, 0);
        check("midrst_busy", bus.o_busy, 0);
        check("midrst_done", bus.o_done, 0);
        check("midrst_prog_len", bus.o_prog_len, 0);
        check("midrst_queue", exp_q.size(), 0);
        exp_q.delete();

        // Randomized programs against the list-walking model.
        for (int t = 0; t < 25; t++) begin
            len = $urandom_range(1, 16);
            prog_q = {};
            for (int i = 0; i < len; i++) prog_q.push_back(4'($urandom_range(0, 15)));
            load_prog();
            check("rand_prog_len", bus.o_prog_len, len);
            push_crst();
            push_model_pass();
            push_done();
            run_and_wait(200);
        end

`ifdef SEQUENCER_LOOP_EN
        // Three passes of REPL incr, no CPU reset between passes.
        prog_q = '{4'h7, 4'h2};
        load_prog();
        push_crst();
        for (int p = 0; p < 3; p++) push_model_pass();
        push_done();
        bus.i_run = 1'b1;
        repeat (9) @(negedge clk);
        bus.i_run = 1'b0;
        wait_done(20);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
